nnue_update_sched: RTL

NNUE_UPDATE_SCHED -- requirements
Module: nnue_update_sched

---
 rtl/nnue_update_sched_if.sv | 27 ++
 rtl/nnue_update_sched.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/nnue_update_sched_if.sv
// Update-request channel into the NNUE accumulator update scheduler.
// master drives a request; slave (the scheduler) returns back-pressure.
interface nnue_update_sched_if;
    localparam int unsigned ROW_W = 7;

    logic             req_valid;
    logic             req_ready;
    logic             req_player;
    logic             req_add;
    logic [ROW_W-1:0] req_row;

    modport master (
        output req_valid,
        output req_player,
        output req_add,
        output req_row,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_player,
        input  req_add,
        input  req_row,
        output req_ready
    );
endinterface

// File: rtl/nnue_update_sched.sv
// Queues NNUE accumulator row updates, issues them one at a time to the accumulator,
// and serves evaluation requests only once every earlier update has completed.
module nnue_update_sched #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    nnue_update_sched_if.slave        req,
    input  logic                      eval_req,
    output logic                      nn_trigger,
    output logic                      nn_player,
    output logic                      nn_add,
    output logic [6:0]                nn_row,
    input  logic                      nn_finish,
    input  logic signed [15:0]        nn_out,
    output logic                      eval_valid,
    output logic signed [15:0]        eval_out,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      err
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned ROW_W = 7;
    localparam int unsigned ENT_W = ROW_W + 2;
    localparam int unsigned TW    = 8;
    localparam int unsigned DW    = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_EVAL  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nx;

    logic [ENT_W-1:0]     mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [TW-1:0]        timer;
    logic                 eval_pending;
    logic signed [DW-1:0] last_out;

    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 timeout_hit;

    assign full        = (count == CW'(DEPTH));
    assign empty       = (count == '0);
    assign push        = req.req_valid && !full;
    assign timeout_hit = (timer == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state; queued updates always win over a pending evaluation
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    state_nx = S_ISSUE;
                    pop      = 1'b1;
                end else if (eval_pending) begin
                    state_nx = S_EVAL;
                end
            end
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT: begin
                if (nn_finish || timeout_hit) begin
                    state_nx = S_IDLE;
                end
            end
            S_EVAL:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded from state and registered datapath only
    always_comb begin
        nn_trigger    = 1'b0;
        eval_valid    = 1'b0;
        eval_out      = '0;
        req.req_ready = !full;
        busy          = (state != S_IDLE) || !empty || eval_pending;
        case (state)
            S_ISSUE: nn_trigger = 1'b1;
            S_EVAL: begin
                eval_valid = 1'b1;
                eval_out   = last_out;
            end
            default: begin
                nn_trigger = 1'b0;
            end
        endcase
    end

    // Queue storage; entries carry no reset since occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req.req_player, req.req_add, req.req_row};
        end
    end

    // Queue pointers, occupancy and the issued-operand registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            nn_player <= 1'b0;
            nn_add    <= 1'b0;
            nn_row    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr                       <= rd_ptr + AW'(1);
                {nn_player, nn_add, nn_row}  <= mem[rd_ptr];
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Completion tracking: timer, result capture, sticky timeout and eval flag
    always_ff @(posedge clk) begin
        if (rst) begin
            timer        <= '0;
            last_out     <= '0;
            err          <= 1'b0;
            eval_pending <= 1'b0;
        end else begin
            if (state == S_WAIT && !nn_finish && !timeout_hit) begin
                timer <= timer + TW'(1);
            end else begin
                timer <= '0;
            end
            if (state == S_WAIT && nn_finish) begin
                last_out <= nn_out;
            end
            if (state == S_WAIT && !nn_finish && timeout_hit) begin
                err <= 1'b1;
            end
            // Pulses arriving while the flag is set, including the EVAL cycle, merge into it
            if (state == S_EVAL) begin
                eval_pending <= 1'b0;
            end else if (eval_req) begin
                eval_pending <= 1'b1;
            end
        end
    end
endmodule
